// File: rtl/morse_pattern_player.sv
// Morse pattern player: plays up to MAX_SYMS dot/dash symbols on q_o, timed by the en_clk tick strobe.
// Define MORSE_LOOP_EN to repeat the pattern forever with a WORD_TICKS low gap between passes.
module morse_pattern_player #(
  parameter int MAX_SYMS   = 8,
  parameter int DOT_TICKS  = 1,
  parameter int DASH_TICKS = 3,
  parameter int GAP_TICKS  = 1,
  parameter int WORD_TICKS = 7,
  parameter int SW         = $clog2(MAX_SYMS + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_clk_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [MAX_SYMS-1:0] data_i,
  input  logic [SW-1:0]       size_i,
  output logic                q_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [SW-1:0]       sym_idx_o
);

  // state  | meaning
  // IDLE   | waiting for start
  // MARK   | q high for a dot or dash
  // GAP    | q low between symbols
  // WGAP   | q low between loop passes
  typedef enum logic [1:0] {S_IDLE, S_MARK, S_GAP, S_WGAP} state_t;

  localparam int T_A  = (DASH_TICKS > WORD_TICKS) ? DASH_TICKS : WORD_TICKS;
  localparam int T_B  = (DOT_TICKS > GAP_TICKS) ? DOT_TICKS : GAP_TICKS;
  localparam int TMAX = (T_A > T_B) ? T_A : T_B;
  localparam int CW   = $clog2(TMAX + 1);

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [MAX_SYMS-1:0] shift_q, shift_d;
  logic [SW-1:0]       len_q, len_d;
  logic [SW-1:0]       idx_q, idx_d;
  logic                q_q, q_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
`ifdef MORSE_LOOP_EN
  logic [MAX_SYMS-1:0] lat_q, lat_d;
`endif

  logic [SW-1:0] size_clamped;
  logic          tick_end;

  function automatic logic [CW-1:0] mark_ticks(input logic is_dash);
    return is_dash ? CW'(DASH_TICKS) : CW'(DOT_TICKS);
  endfunction

  assign size_clamped = (size_i > SW'(MAX_SYMS)) ? SW'(MAX_SYMS) : size_i;
  // cnt holds remaining ticks of the current segment; a zero count ends it defensively
  assign tick_end     = en_clk_i && (cnt_q <= CW'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    len_d   = len_q;
    idx_d   = idx_q;
    q_d     = q_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef MORSE_LOOP_EN
    lat_d   = lat_q;
`endif
    if (abort_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      q_d     = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            shift_d = data_i;
            len_d   = size_clamped;
`ifdef MORSE_LOOP_EN
            lat_d   = data_i;
`endif
            if (size_clamped == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = S_MARK;
              cnt_d   = mark_ticks(data_i[MAX_SYMS-1]);
              idx_d   = '0;
              q_d     = 1'b1;
              busy_d  = 1'b1;
            end
          end
        end
        S_MARK: begin
          if (tick_end) begin
            q_d = 1'b0;
            if (idx_q == len_q - SW'(1)) begin
              done_d = 1'b1;
              idx_d  = '0;
`ifdef MORSE_LOOP_EN
              state_d = S_WGAP;
              cnt_d   = CW'(WORD_TICKS);
`else
              state_d = S_IDLE;
              cnt_d   = '0;
              busy_d  = 1'b0;
`endif
            end else begin
              state_d = S_GAP;
              cnt_d   = CW'(GAP_TICKS);
              shift_d = shift_q << 1;
              idx_d   = idx_q + SW'(1);
            end
          end else if (en_clk_i) begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        S_GAP: begin
          if (tick_end) begin
            state_d = S_MARK;
            cnt_d   = mark_ticks(shift_q[MAX_SYMS-1]);
            q_d     = 1'b1;
          end else if (en_clk_i) begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        S_WGAP: begin
`ifdef MORSE_LOOP_EN
          if (tick_end) begin
            state_d = S_MARK;
            shift_d = lat_q;
            cnt_d   = mark_ticks(lat_q[MAX_SYMS-1]);
            idx_d   = '0;
            q_d     = 1'b1;
          end else if (en_clk_i) begin
            cnt_d = cnt_q - CW'(1);
          end
`else
          state_d = S_IDLE;
          cnt_d   = '0;
          q_d     = 1'b0;
          busy_d  = 1'b0;
`endif
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      q_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MORSE_LOOP_EN
      lat_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      q_q     <= q_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef MORSE_LOOP_EN
      lat_q   <= lat_d;
`endif
    end
  end

  assign q_o       = q_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign sym_idx_o = idx_q;

endmodule
